// File: rtl/datapath_param_if.sv
// Memory handshake bundle between datapath_param (master) and a memory model (slave).
interface datapath_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/datapath_param.sv
// Accumulator datapath: register file on a shared bus, ALU with a multi-cycle
// shift-add multiplier, and a valid/ready memory port.
module datapath_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int MUL_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            reg_ctrl,
    input  logic [2:0]             bus_sel,
    input  logic                   alu_start,
    input  logic                   mem_req,
    input  logic                   mem_we,
    datapath_param_if.master       mem,
    output logic [3:0]             opcode,
    output logic                   alu_busy,
    output logic                   mem_busy,
    output logic                   alu_done,
    output logic                   mem_done,
    output logic [2:0]             flags
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} alu_state_e;
    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE} mem_state_e;

    alu_state_e alu_state_q, alu_state_d;
    mem_state_e mem_state_q, mem_state_d;

    logic [ADDR_W-1:0]   ar_q, ar_d, pc_q, pc_d, addr_q, addr_d;
    logic [DATA_W-1:0]   dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d, mdr_q, mdr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic [2:0]          flags_q, flags_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_fin;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   bus, alu_res, alu_wr_val;
    logic [DATA_W:0]     sum;
    logic                alu_c, alu_wr, alu_wr_c;
    logic [2:0]          alu_op;

    function automatic logic [DATA_W-1:0] upd_d(input logic [DATA_W-1:0] cur,
                                                input logic [2:0] ctl,
                                                input logic [DATA_W-1:0] src);
        if (ctl[2]) return '0;
        if (ctl[1]) return cur + DATA_W'(1);
        if (ctl[0]) return src;
        return cur;
    endfunction

    function automatic logic [ADDR_W-1:0] upd_a(input logic [ADDR_W-1:0] cur,
                                                input logic [2:0] ctl,
                                                input logic [ADDR_W-1:0] src);
        if (ctl[2]) return '0;
        if (ctl[1]) return cur + ADDR_W'(1);
        if (ctl[0]) return src;
        return cur;
    endfunction

    assign opcode   = ir_q[DATA_W-1:DATA_W-4];
    assign alu_op   = opcode[2:0];
    assign alu_busy = (alu_state_q != IDLE);
    assign alu_done = (alu_state_q == DONE);
    assign mem_busy = (mem_state_q != M_IDLE);
    assign mem_done = (mem_state_q == M_DONE);
    assign flags    = flags_q;

    assign mem.mem_valid = (mem_state_q == M_WAIT);
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wr    = wr_q;

    always_comb begin
        bus = '0;
        case (bus_sel)
            3'd1:    bus = DATA_W'(ar_q);
            3'd2:    bus = DATA_W'(pc_q);
            3'd3:    bus = dr_q;
            3'd4:    bus = ac_q;
            3'd5:    bus = ir_q;
            3'd6:    bus = tr_q;
            3'd7:    bus = mdr_q;
            default: bus = '0;
        endcase
    end

    // Single-cycle ALU results; opcode 111 here only serves the MUL_EN=0 case.
    always_comb begin
        sum     = {1'b0, dr_q} + {1'b0, ac_q};
        alu_res = '0;
        alu_c   = 1'b0;
        case (alu_op)
            3'b000: begin alu_res = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
            3'b001: begin alu_res = {dr_q[DATA_W-2:0], 1'b0}; alu_c = dr_q[DATA_W-1]; end
            3'b010: alu_res = ~(dr_q ^ ac_q);
            3'b011: begin alu_res = {dr_q[DATA_W-1], dr_q[DATA_W-1:1]}; alu_c = dr_q[0]; end
            3'b100: alu_res = dr_q;
            3'b101: alu_res = ac_q;
            3'b110: alu_res = '0 - dr_q;
            default: alu_res = '0;
        endcase
    end

    assign prod_fin = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_state_d = alu_state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        alu_wr      = 1'b0;
        alu_wr_val  = alu_res;
        alu_wr_c    = alu_c;
        case (alu_state_q)
            IDLE: if (alu_start) begin
                if (alu_op == 3'b111 && MUL_EN != 0) begin
                    mcand_d     = {{DATA_W{1'b0}}, dr_q};
                    mplier_d    = ac_q;
                    prod_d      = '0;
                    cnt_d       = '0;
                    alu_state_d = RUN;
                end else begin
                    alu_wr      = 1'b1;
                    alu_state_d = DONE;
                end
            end
            RUN: begin
                prod_d   = prod_fin;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    alu_wr      = 1'b1;
                    alu_wr_val  = prod_fin[DATA_W-1:0];
                    alu_wr_c    = |prod_fin[2*DATA_W-1:DATA_W];
                    alu_state_d = DONE;
                end
            end
            DONE:    alu_state_d = IDLE;
            default: alu_state_d = IDLE;
        endcase
    end

    always_comb begin
        ar_d = upd_a(ar_q, reg_ctrl[2:0], bus[ADDR_W-1:0]);
        pc_d = upd_a(pc_q, reg_ctrl[5:3], bus[ADDR_W-1:0]);
        dr_d = upd_d(dr_q, reg_ctrl[8:6], bus);
        tr_d = upd_d(tr_q, reg_ctrl[14:12], bus);
        ir_d = reg_ctrl[15] ? bus : ir_q;
        // ALU owns AC from the start cycle until it returns to IDLE.
        if (alu_wr)
            ac_d = alu_wr_val;
        else if (alu_busy || alu_start)
            ac_d = ac_q;
        else
            ac_d = upd_d(ac_q, reg_ctrl[11:9], bus);
        flags_d = alu_wr ? {alu_wr_val[DATA_W-1], (alu_wr_val == '0), alu_wr_c} : flags_q;
    end

    always_comb begin
        mem_state_d = mem_state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        mdr_d       = mdr_q;
        case (mem_state_q)
            M_IDLE: if (mem_req) begin
                addr_d      = ar_q;
                wdata_d     = bus;
                wr_d        = mem_we;
                mem_state_d = M_WAIT;
            end
            M_WAIT: if (mem.mem_ready) begin
                if (!wr_q) mdr_d = mem.mem_rdata;
                mem_state_d = M_DONE;
            end
            M_DONE:  mem_state_d = M_IDLE;
            default: mem_state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_state_q <= IDLE;
            mem_state_q <= M_IDLE;
            ar_q        <= '0;
            pc_q        <= '0;
            dr_q        <= '0;
            ac_q        <= '0;
            ir_q        <= '0;
            tr_q        <= '0;
            mdr_q       <= '0;
            flags_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            alu_state_q <= alu_state_d;
            mem_state_q <= mem_state_d;
            ar_q        <= ar_d;
            pc_q        <= pc_d;
            dr_q        <= dr_d;
            ac_q        <= ac_d;
            ir_q        <= ir_d;
            tr_q        <= tr_d;
            mdr_q       <= mdr_d;
            flags_q     <= flags_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_datapath_param.sv
// Directed self-checking bench for datapath_param (DATA_W=8, ADDR_W=4, MUL_EN=1).
module tb_datapath_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] reg_ctrl = '0;
    logic [2:0]  bus_sel = '0;
    logic        alu_start = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  opcode;
    logic        alu_busy, mem_busy, alu_done, mem_done;
    logic [2:0]  flags;
    int          n_cmp = 0;
    int          n_bad = 0;

    datapath_param_if #(.DATA_W(8), .ADDR_W(4)) mem_if ();

    datapath_param #(.DATA_W(8), .ADDR_W(4), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .reg_ctrl(reg_ctrl), .bus_sel(bus_sel),
        .alu_start(alu_start), .mem_req(mem_req), .mem_we(mem_we), .mem(mem_if),
        .opcode(opcode), .alu_busy(alu_busy), .mem_busy(mem_busy),
        .alu_done(alu_done), .mem_done(mem_done), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [7:0] v);
        mem_we = 1'b0; mem_req = 1'b1;
        tick();
        mem_req = 1'b0; mem_if.mem_ready = 1'b1; mem_if.mem_rdata = v;
        tick();
        mem_if.mem_ready = 1'b0;
        tick();
    endtask

    // ld_bit: 0=AR, 3=PC, 6=DR, 9=AC, 12=TR, 15=IR
    task automatic load_reg(input int unsigned ld_bit, input logic [7:0] v);
        load_mdr(v);
        bus_sel = 3'd7;
        reg_ctrl = 16'(1) << ld_bit;
        tick();
        reg_ctrl = '0;
    endtask

    task automatic read_reg(input logic [2:0] sel, output logic [7:0] v);
        bus_sel = sel; mem_we = 1'b1; mem_req = 1'b1;
        tick();
        v = mem_if.mem_wdata;
        mem_req = 1'b0; mem_we = 1'b0; mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        mem_if.mem_ready = 1'b0; mem_if.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({alu_busy, mem_busy, alu_done, mem_done} !== 4'b0) begin
            n_bad++; $display("FAIL reset_status got %b want 0000", {alu_busy, mem_busy, alu_done, mem_done});
        end
        n_cmp++;
        if ({mem_if.mem_valid, mem_if.mem_wr, mem_if.mem_addr, mem_if.mem_wdata} !== 14'b0) begin
            n_bad++; $display("FAIL reset_mem got %b want 0", {mem_if.mem_valid, mem_if.mem_wr, mem_if.mem_addr, mem_if.mem_wdata});
        end
        n_cmp++;
        if ({opcode, flags} !== 7'b0) begin
            n_bad++; $display("FAIL reset_op_flags got %b want 0", {opcode, flags});
        end
        #3 rst_n = 1'b1;
        tick();
        read_reg(3'd4, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL reset_ac got %h want 00", v); end
    endtask

    task automatic test_alu_ops();
        // {ir, dr, ac, expected ac, expected flags nzc}
        logic [34:0] vec [8];
        logic [7:0]  v;
        vec = '{ {8'h00, 8'h0F, 8'h01, 8'h10, 3'b000},
                 {8'h00, 8'hFF, 8'h01, 8'h00, 3'b011},
                 {8'h30, 8'h81, 8'h00, 8'hC0, 3'b101},
                 {8'h10, 8'h81, 8'h00, 8'h02, 3'b001},
                 {8'h20, 8'hF0, 8'h3C, 8'h33, 3'b000},
                 {8'h40, 8'h80, 8'h00, 8'h80, 3'b100},
                 {8'h50, 8'h12, 8'h00, 8'h00, 3'b010},
                 {8'h60, 8'h01, 8'h00, 8'hFF, 3'b100} };
        for (int i = 0; i < 8; i++) begin
            load_reg(15, vec[i][34:27]);
            load_reg(6, vec[i][26:19]);
            load_reg(9, vec[i][18:11]);
            alu_start = 1'b1;
            tick();
            alu_start = 1'b0;
            n_cmp++;
            if (alu_done !== 1'b1) begin n_bad++; $display("FAIL alu_done_pulse[%0d] got %b want 1", i, alu_done); end
            tick();
            n_cmp++;
            if ({alu_done, alu_busy} !== 2'b00) begin n_bad++; $display("FAIL alu_idle[%0d] got %b want 00", i, {alu_done, alu_busy}); end
            n_cmp++;
            if (flags !== vec[i][2:0]) begin n_bad++; $display("FAIL alu_flags[%0d] got %b want %b", i, flags, vec[i][2:0]); end
            read_reg(3'd4, v);
            n_cmp++;
            if (v !== vec[i][10:3]) begin n_bad++; $display("FAIL alu_ac[%0d] got %h want %h", i, v, vec[i][10:3]); end
        end
    endtask

    task automatic test_multiply();
        int busy_cnt = 0;
        int done_cnt = 0;
        logic [7:0] v;
        load_reg(15, 8'h70);
        load_reg(6, 8'h0D);
        load_reg(9, 8'h0B);
        alu_start = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            if (alu_busy) busy_cnt++;
            if (alu_done) done_cnt++;
            // Retrigger and change DR mid-run; neither may affect the result.
            if (i == 2) begin alu_start = 1'b1; bus_sel = 3'd7; reg_ctrl = 16'h0040; end
            else begin alu_start = 1'b0; reg_ctrl = '0; end
            tick();
        end
        n_cmp++;
        if (busy_cnt != 9) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 9", busy_cnt); end
        n_cmp++;
        if (done_cnt != 1) begin n_bad++; $display("FAIL mul_done_pulses got %0d want 1", done_cnt); end
        n_cmp++;
        if (flags !== 3'b100) begin n_bad++; $display("FAIL mul_flags got %b want 100", flags); end
        read_reg(3'd4, v);
        n_cmp++;
        if (v !== 8'h8F) begin n_bad++; $display("FAIL mul_ac got %h want 8f", v); end
    endtask

    task automatic test_mem_read();
        int vcnt = 0;
        int dcnt = 0;
        logic [7:0] v;
        load_reg(0, 8'h05);
        mem_we = 1'b0; mem_req = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            if (mem_if.mem_valid) vcnt++;
            if (mem_done) dcnt++;
            if (i == 0) begin
                n_cmp++;
                if ({mem_if.mem_wr, mem_if.mem_addr} !== 5'h05) begin
                    n_bad++; $display("FAIL mem_addr_wr got %b want 00101", {mem_if.mem_wr, mem_if.mem_addr});
                end
            end
            mem_req = (i < 2);
            mem_if.mem_ready = (i == 3);
            mem_if.mem_rdata = 8'hA5;
            tick();
        end
        mem_if.mem_ready = 1'b0;
        n_cmp++;
        if (vcnt != 4) begin n_bad++; $display("FAIL mem_valid_cycles got %0d want 4", vcnt); end
        n_cmp++;
        if (dcnt != 1) begin n_bad++; $display("FAIL mem_done_pulses got %0d want 1", dcnt); end
        read_reg(3'd7, v);
        n_cmp++;
        if (v !== 8'hA5) begin n_bad++; $display("FAIL mem_mdr got %h want a5", v); end
        read_reg(3'd1, v);
        n_cmp++;
        if (v !== 8'h05) begin n_bad++; $display("FAIL ar_zext got %h want 05", v); end
    endtask

    task automatic test_pc();
        logic [7:0] v;
        load_reg(3, 8'h0F);
        reg_ctrl = 16'h0010; tick(); reg_ctrl = '0;
        read_reg(3'd2, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL pc_wrap got %h want 00", v); end
        load_reg(3, 8'h07);
        reg_ctrl = 16'h0010; tick(); reg_ctrl = '0;
        read_reg(3'd2, v);
        n_cmp++;
        if (v !== 8'h08) begin n_bad++; $display("FAIL pc_inc got %h want 08", v); end
        load_reg(3, 8'h03);
        load_mdr(8'h09);
        bus_sel = 3'd7; reg_ctrl = 16'h0018; tick(); reg_ctrl = '0;
        read_reg(3'd2, v);
        n_cmp++;
        if (v !== 8'h04) begin n_bad++; $display("FAIL pc_inc_over_ld got %h want 04", v); end
        bus_sel = 3'd7; reg_ctrl = 16'h0038; tick(); reg_ctrl = '0;
        read_reg(3'd2, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL pc_clr_priority got %h want 00", v); end
    endtask

    task automatic test_ac_override();
        logic [7:0] v;
        load_reg(15, 8'h40);
        load_reg(6, 8'h42);
        load_reg(9, 8'h11);
        alu_start = 1'b1; reg_ctrl = 16'h0800;
        tick();
        alu_start = 1'b0; reg_ctrl = '0;
        tick();
        read_reg(3'd4, v);
        n_cmp++;
        if (v !== 8'h42) begin n_bad++; $display("FAIL ac_alu_wins got %h want 42", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        load_reg(0, 8'h09);
        load_reg(15, 8'h70);
        load_reg(6, 8'h0D);
        load_reg(9, 8'h0B);
        alu_start = 1'b1;
        tick();
        alu_start = 1'b0; bus_sel = 3'd4; mem_we = 1'b1; mem_req = 1'b1;
        tick();
        mem_req = 1'b0; mem_we = 1'b0;
        tick();
        n_cmp++;
        if ({alu_busy, mem_if.mem_valid, mem_if.mem_wr} !== 3'b111) begin
            n_bad++; $display("FAIL concurrent_busy got %b want 111", {alu_busy, mem_if.mem_valid, mem_if.mem_wr});
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({alu_busy, mem_busy, alu_done, mem_done, mem_if.mem_valid, mem_if.mem_wr} !== 6'b0) begin
            n_bad++; $display("FAIL midreset_status got %b want 0", {alu_busy, mem_busy, alu_done, mem_done, mem_if.mem_valid, mem_if.mem_wr});
        end
        n_cmp++;
        if ({mem_if.mem_addr, mem_if.mem_wdata, opcode, flags} !== 19'b0) begin
            n_bad++; $display("FAIL midreset_regs got %h want 0", {mem_if.mem_addr, mem_if.mem_wdata, opcode, flags});
        end
        #1 rst_n = 1'b1;
        mem_if.mem_ready = 1'b1; mem_if.mem_rdata = 8'h5A;
        repeat (12) tick();
        mem_if.mem_ready = 1'b0;
        n_cmp++;
        if ({alu_busy, mem_busy, flags} !== 5'b0) begin
            n_bad++; $display("FAIL postreset_idle got %b want 0", {alu_busy, mem_busy, flags});
        end
        read_reg(3'd4, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL postreset_ac got %h want 00", v); end
        read_reg(3'd7, v);
        n_cmp++;
        if (v !== 8'h00) begin n_bad++; $display("FAIL postreset_mdr got %h want 00", v); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_multiply();
        test_mem_read();
        test_pc();
        test_ac_override();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/datapath_param.md
DATAPATH_PARAM -- requirements
Module: datapath_param

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, setting the bus, DR, AC, IR, TR, MDR and ALU width (minimum 8).
REQ-002 The module SHALL have parameter ADDR_W, default 4, setting the AR, PC and memory address width (at most DATA_W).
REQ-003 The module SHALL have parameter MUL_EN, default 1, which enables ALU opcode 111 (multiply); when 0, opcode 111 produces result 0.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 The module SHALL have port reg_ctrl, input, 16 bits: {ir_ld, tr[2:0], ac[2:0], dr[2:0], pc[2:0], ar[2:0]}, where each 3-bit field is {clr, inc, ld}.
REQ-007 The module SHALL have port bus_sel, input, 3 bits: the bus source select.
REQ-008 The module SHALL have port alu_start, input, 1 bit: starts the ALU operation selected by opcode[2:0].
REQ-009 The module SHALL have port mem_req, input, 1 bit: starts a memory access.
REQ-010 The module SHALL have port mem_we, input, 1 bit: selects write (1) or read (0), sampled with mem_req.
REQ-011 The module SHALL have the memory port: mem_valid (out, 1), mem_ready (in, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_wr (out, 1) and mem_rdata (in, DATA_W).
REQ-012 The module SHALL have port opcode, output, 4 bits: IR[DATA_W-1:DATA_W-4].
REQ-013 The module SHALL have ports alu_busy and mem_busy, outputs, 1 bit each.
REQ-014 The module SHALL have ports alu_done and mem_done, outputs, 1 bit each: one-cycle pulses.
REQ-015 The module SHALL have port flags, output, 3 bits: {n, z, c}.

Function
REQ-016 Bus sources: bus_sel 0 = 0, 1 = AR, 2 = PC, 3 = DR, 4 = AC, 5 = IR, 6 = TR, 7 = MDR; AR and PC are zero-extended onto the bus.
REQ-017 Per-register priority SHALL be clr > inc > ld; inc wraps modulo 2^width; ld takes the bus (AR and PC take bus[ADDR_W-1:0]); IR supports load only.
REQ-018 ALU operands: operand = DR, reg_value = AC. Operations by opcode:
- 000: add, c = carry out.
- 001: shift left, c = operand MSB.
- 010: xnor.
- 011: arithmetic shift right, c = operand LSB.
- 100: pass DR.
- 101: pass AC.
- 110: two's complement of DR.
- 111: unsigned multiply, keeping the low DATA_W bits, c = OR of the high half.
- Every operation not listed with a c source above SHALL clear c.
REQ-019 ALU FSM states SHALL be IDLE, RUN and DONE. In IDLE, alu_start with opcode 000-110 SHALL write AC and flags at the next edge and then enter DONE.
REQ-020 alu_start with opcode 111 SHALL enter RUN, perform shift-add over exactly DATA_W cycles, write AC and flags on the last RUN edge, then enter DONE.
REQ-021 In DONE, alu_done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; alu_busy SHALL be 1 in RUN and DONE.
REQ-022 alu_start SHALL be ignored while alu_busy is 1; DR and AC SHALL be captured at start, so changes during RUN do not affect the result.
REQ-023 The reg_ctrl AC field SHALL be ignored while alu_busy is 1, and also in the alu_start cycle (the ALU write wins).
REQ-024 Flags: z = (result == 0) and n = result MSB; flags SHALL update only on ALU writes to AC.
REQ-025 Memory FSM states SHALL be M_IDLE, M_WAIT and M_DONE. In M_IDLE, mem_req SHALL latch mem_addr = AR, mem_wdata = bus and mem_wr = mem_we, then enter M_WAIT.
REQ-026 In M_WAIT, mem_valid SHALL be 1 and address, data and write SHALL be held stable. On the first edge with mem_ready = 1, a read SHALL load MDR from mem_rdata and the FSM SHALL enter M_DONE.
REQ-027 In M_DONE, mem_done SHALL be 1 for one cycle, then the FSM SHALL return to M_IDLE; mem_busy SHALL be 1 in M_WAIT and M_DONE; mem_req SHALL be ignored while mem_busy is 1.
REQ-028 The ALU and memory FSMs SHALL operate independently and may be busy simultaneously.

Reset
REQ-029 rst_n low SHALL immediately clear all registers (AR, PC, DR, AC, IR, TR, MDR), the flags and the multiply state.
REQ-030 rst_n low SHALL force both FSMs to their idle states and drive mem_valid, mem_wr, mem_addr, mem_wdata, the busy outputs and the done outputs to 0.
REQ-031 Reset mid-operation SHALL abort the operation with no AC or MDR write after release; operation resumes at the first rising edge after rst_n goes high.

Verification
REQ-032 Add with DR = 0x0F, AC = 0x01, opcode 000, alu_start -> AC = 0x10, flags = 000, alu_done one cycle later.
REQ-033 Add with DR = 0xFF, AC = 0x01 -> AC = 0x00, z = 1, c = 1; with opcode 011 and DR = 0x81 -> AC = 0xC0, n = 1, c = 1.
REQ-034 Multiply with DR = 0x0D, AC = 0x0B, opcode 111 -> alu_busy for 9 cycles, AC = 0x8F, c = 0; a second alu_start during RUN is ignored.
REQ-035 Read with AR = 0x5, mem_ready asserted after 3 wait cycles, mem_rdata = 0xA5 -> mem_valid held for 4 cycles, MDR = 0xA5, then one mem_done pulse.
REQ-036 PC = 0xF with inc -> PC = 0x0; ld, inc and clr together -> PC = 0.
REQ-037 rst_n low in the middle of a multiply or memory wait -> all outputs 0 immediately and AC unchanged from 0 after release.
